spart_rx_fifo: RTL and testbench

- Receive-side buffer between the SPART receiver (rec_buff/RDA) and the processor bus interface.
- Captures each byte the receiver flags as available, acknowledges it so the receiver can return to idle, and queues it in a DEPTH-entry FIFO.
- The processor drains the FIFO and reads status through the IOCS/IORW/IOADDR bus.

---
 rtl/spart_rx_fifo.sv | 117 +++++++++++
 tb/tb_spart_rx_fifo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/spart_rx_fifo.sv
// spart_rx_fifo: receive-side byte FIFO between the SPART receiver and the
// processor bus. A two-state capture FSM takes one byte per RDA assertion,
// strobes rx_ack back to the receiver, and queues the byte. The processor
// pops data at ioaddr 00 and reads status {overrun, full, rda} at ioaddr 01.
// Optional macro RX_FIFO_THRESH_EN enables the registered rx_irq fill-level
// interrupt; without it rx_irq is tied low.
module spart_rx_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int THRESH     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_rda,
   output logic       rx_ack,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   output logic [7:0] rd_data,
   output logic       rda,
   output logic       rx_irq
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);

   typedef enum logic {IDLE, WAIT_CLR} state_e;

   state_e                  state_q, state_d;
   logic [7:0]              mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]     count_q, count_d;
   logic                    overrun_q, overrun_d;
   logic                    full, push_req, wr_en, data_rd, pop, stat_rd;

   assign full     = (count_q == DEPTH_C);
   assign rda      = (count_q != '0);
   assign data_rd  = iocs & iorw & (ioaddr == 2'b00);
   assign stat_rd  = iocs & iorw & (ioaddr == 2'b01);
   assign pop      = data_rd & rda;
   // One capture attempt per RDA assertion: only from IDLE.
   assign push_req = (state_q == IDLE) & rx_rda;
   // A pop in the same cycle frees a slot even when full.
   assign wr_en    = push_req & (~full | pop);
   // Ack is issued even when the byte is dropped so the receiver is freed;
   // held low while in reset.
   assign rx_ack   = push_req & rst_n;

   // Next-state: capture FSM, pointers, occupancy and sticky overrun.
   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      overrun_d = overrun_q;
      case (state_q)
         IDLE:     if (rx_rda)  state_d = WAIT_CLR;
         WAIT_CLR: if (!rx_rda) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // A status read clears overrun, but a new drop in that cycle wins.
      if (push_req && !wr_en) overrun_d = 1'b1;
      else if (stat_rd)       overrun_d = 1'b0;
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   // Storage array; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= rx_data;
   end

   // Bus read mux: head byte on a pop, status word, otherwise zero.
   always_comb begin
      rd_data = 8'h00;
      if (pop)          rd_data = mem[rd_ptr_q];
      else if (stat_rd) rd_data = {5'b0, overrun_q, full, rda};
   end

`ifdef RX_FIFO_THRESH_EN
   localparam logic [DEPTH_LOG2:0] THRESH_C = (DEPTH_LOG2+1)'(THRESH);
   logic rx_irq_q;

   // Fill-level interrupt tracks the occupancy being loaded this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rx_irq_q <= 1'b0;
      else        rx_irq_q <= (count_d >= THRESH_C);
   end
   assign rx_irq = rx_irq_q;
`else
   assign rx_irq = 1'b0;
`endif

endmodule

// File: tb/tb_spart_rx_fifo.sv
// Directed bench for spart_rx_fifo: capture handshake, full/overrun, push+pop
// at full and empty, pointer wrap, rx_irq and asynchronous reset.
module tb_spart_rx_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_rda;
   logic       rx_ack;
   logic       iocs, iorw;
   logic [1:0] ioaddr;
   logic [7:0] rd_data;
   logic       rda;
   logic       rx_irq;

   int checks = 0;
   int errors = 0;
   int ack_cnt = 0;

`ifdef RX_FIFO_THRESH_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   spart_rx_fifo #(.DEPTH_LOG2(4), .THRESH(8)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rda(rx_rda),
      .rx_ack(rx_ack), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
      .rd_data(rd_data), .rda(rda), .rx_irq(rx_irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rx_ack) ack_cnt <= ack_cnt + 1;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %02h exp %02h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a byte, check the single ack pulse, then drop RDA.
   task automatic push(input logic [7:0] b);
      rx_data = b;
      rx_rda  = 1'b1;
      #1 chk("ack_hi", {7'b0, rx_ack}, 8'h01);
      step();
      chk("ack_lo_wait", {7'b0, rx_ack}, 8'h00);
      rx_rda = 1'b0;
      step();
   endtask

   task automatic bus_rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
      iocs = 1'b1; iorw = 1'b1; ioaddr = a;
      #1 chk(tag, rd_data, exp);
      step();
      iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
   endtask

   initial begin
      int a0;
      rst_n = 1'b0; rx_data = 8'h00; rx_rda = 1'b0;
      iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
      step(); step();
      chk("rst_ack",  {7'b0, rx_ack}, 8'h00);
      chk("rst_rda",  {7'b0, rda},    8'h00);
      chk("rst_irq",  {7'b0, rx_irq}, 8'h00);
      chk("rst_data", rd_data,        8'h00);
      rst_n = 1'b1;
      step();
      bus_rd("rst_status", 2'b01, 8'h00);

      // Single byte A5, RDA held an extra cycle: only one capture.
      a0 = ack_cnt;
      rx_data = 8'hA5; rx_rda = 1'b1;
      #1 chk("a5_ack", {7'b0, rx_ack}, 8'h01);
      chk("a5_rda_before", {7'b0, rda}, 8'h00);
      step();
      chk("a5_rda_after", {7'b0, rda}, 8'h01);
      step();
      chk("a5_ack_held", {7'b0, rx_ack}, 8'h00);
      rx_rda = 1'b0;
      step();
      chk("a5_ack_count", 8'(ack_cnt - a0), 8'h01);
      bus_rd("a5_read", 2'b00, 8'hA5);
      chk("a5_rda_empty", {7'b0, rda}, 8'h00);

      // Fill, overflow with 55, check sticky overrun and drain.
      for (int i = 0; i < 16; i++) push(8'(i));
      push(8'h55);
      bus_rd("ovr_status1", 2'b01, 8'h07);
      bus_rd("ovr_status2", 2'b01, 8'h03);
      for (int i = 0; i < 16; i++) bus_rd("ovr_drain", 2'b00, 8'(i));
      bus_rd("ovr_empty_status", 2'b01, 8'h00);

      // Full FIFO, push 77 in the same cycle as a pop.
      for (int i = 0; i < 16; i++) push(8'(i));
      rx_data = 8'h77; rx_rda = 1'b1;
      iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
      #1 chk("fullpp_read", rd_data, 8'h00);
      chk("fullpp_ack", {7'b0, rx_ack}, 8'h01);
      step();
      iocs = 1'b0; iorw = 1'b0; rx_rda = 1'b0;
      step();
      bus_rd("fullpp_status", 2'b01, 8'h03);
      for (int i = 1; i < 16; i++) bus_rd("fullpp_drain", 2'b00, 8'(i));
      bus_rd("fullpp_last", 2'b00, 8'h77);

      // Empty read, then push+pop on an empty FIFO.
      bus_rd("empty_read", 2'b00, 8'h00);
      bus_rd("empty_status", 2'b01, 8'h00);
      push(8'h3C);
      bus_rd("rd_3c", 2'b00, 8'h3C);
      rx_data = 8'h5A; rx_rda = 1'b1;
      iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
      #1 chk("emptypp_read", rd_data, 8'h00);
      step();
      iocs = 1'b0; iorw = 1'b0; rx_rda = 1'b0;
      step();
      bus_rd("emptypp_5a", 2'b00, 8'h5A);

      // Pointer wrap: 40 push/pop pairs.
      for (int i = 0; i < 40; i++) begin
         push(8'(i * 3));
         bus_rd("wrap_status", 2'b01, 8'h01);
         bus_rd("wrap_data", 2'b00, 8'(i * 3));
      end

      // Threshold interrupt around 8 entries.
      for (int i = 0; i < 7; i++) push(8'(8'hC0 + i));
      chk("irq_7", {7'b0, rx_irq}, 8'h00);
      push(8'hC7);
      chk("irq_8", {7'b0, rx_irq}, {7'b0, IRQ_ON});
      bus_rd("irq_pop", 2'b00, 8'hC0);
      chk("irq_after_pop", {7'b0, rx_irq}, 8'h00);

      // Async reset mid-stream with RDA and a status read active.
      rx_data = 8'hE1; rx_rda = 1'b1;
      iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b01;
      #2 rst_n = 1'b0;
      #1 chk("arst_ack", {7'b0, rx_ack}, 8'h00);
      chk("arst_rda",  {7'b0, rda},    8'h00);
      chk("arst_irq",  {7'b0, rx_irq}, 8'h00);
      chk("arst_data", rd_data,        8'h00);
      iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
      step();
      rst_n = 1'b1;
      #1 chk("arst_recap_ack", {7'b0, rx_ack}, 8'h01);
      step();
      rx_rda = 1'b0;
      step();
      bus_rd("arst_recap_data", 2'b00, 8'hE1);
      chk("arst_final_rda", {7'b0, rda}, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #500000;
      errors++;
      $display("FAIL timeout got 00 exp 01");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
